modn_updown_counter_prog: RTL
=============================

// Module: modn_updown_counter_prog
// PURPOSE
//  Runtime-programmable modulus up/down counter; next generation of the fixed-N
//  mod-N counter. Adds enable, step size, parallel load, wrap/saturate mode,
//  terminal-count and event flags. Used as timebase/index generator and cascadable
//  via wrap_o pulse into the next stage's en.
// PARAMETERS
//  WIDTH        8   counter and modulus width in bits
//  DEFAULT_MOD  10  modulus M after reset (2 <= DEFAULT_MOD <= 2**WIDTH-1)
//  STEP_W       4   width of step input
// PORTS
//  clk       in   1        clock, all state on rising edge
//  reset     in   1        synchronous, active-high
//  en        in   1        count enable
//  up_dn     in   1        1 = count up, 0 = count down
//  sat_mode  in   1        1 = saturate at bounds, 0 = wrap modulo M
//  step      in   STEP_W   increment/decrement per enabled cycle
//  load      in   1        parallel load strobe
//  load_val  in   WIDTH    value to load
//  mod_wr    in   1        modulus write strobe
//  mod_val   in   WIDTH    new modulus M
//  count     out  WIDTH    current count, always 0..M-1
//  mod_q     out  WIDTH    current modulus M
//  tc        out  1        comb: (up_dn & count==M-1) | (~up_dn & count==0)
//  wrap_o    out  1        reg pulse: count wrapped on previous edge
//  sat_o     out  1        reg pulse: count clamped on previous edge
//  err_o     out  1        reg pulse: illegal mod_val/load_val/step last cycle
// BEHAVIOUR
//  Reset: count=0, mod_q=DEFAULT_MOD, wrap_o=sat_o=err_o=0.
//  Priority per edge: reset > mod_wr > load > en; lower-priority ops dropped.
//  wrap_o/sat_o/err_o are 1-cycle pulses, default 0 every cycle.
//  mod_wr: mod_val<2 -> ignored, err_o=1, count held. Else mod_q<=mod_val;
//   if count>=mod_val then count<=0, else count held.
//  load: load_val<M -> count<=load_val; else count<=M-1, err_o=1.
//  en with step==0: hold, no flags. step>=M: hold, err_o=1.
//  Up (step<M): s=count+step computed in WIDTH+1 bits.
//   s<M -> count<=s. s>=M: wrap mode count<=s-M, wrap_o=1;
//   sat mode count<=M-1, sat_o=1 (even if already at M-1).
//  Down (step<M): count>=step -> count<=count-step.
//   else wrap mode count<=count+M-step, wrap_o=1; sat mode count<=0, sat_o=1.
//  en=0: count held, no flags. Single-cycle latency for all updates.
//  Mode/direction/step may change any cycle; take effect on that edge.
//  Reset mid-count: next edge forces reset values regardless of other inputs.
//  WIDTH-bit overflow impossible: all intermediates WIDTH+1 bits.
// TESTING
//  Reset, en=1 up step=1 M=10: 0..9,0; wrap_o high cycle after 9->0; tc at 9.
//  Down wrap M=10 step=3 from 1: 1->8 (wrap_o), 8->5; sat_mode: 1->0, sat_o=1.
//  mod_wr 5 while count=7 -> count=0, mod_q=5; mod_wr 1 -> err_o, mod_q kept.
//  load 12 with M=10 -> count=9, err_o; load+mod_wr same cycle -> load dropped.
//  step=10 with M=10 -> hold + err_o; step=0 -> hold, no flags.
//  reset asserted mid-count with load/en active -> count=0, mod_q=DEFAULT_MOD.

Source files
------------

// File: rtl/modn_updown_counter_prog.sv
// Runtime-programmable modulus up/down counter.
// Supports enable, programmable step, parallel load, wrap or saturate at the
// bounds, a combinational terminal-count flag and registered one-cycle event
// pulses (wrap, saturate, illegal input). Cascade stages by feeding wrap_o
// into the next stage's en.
module modn_updown_counter_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_MOD = 10,
    parameter int STEP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_dn,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              mod_wr,
    input  logic [WIDTH-1:0]  mod_val,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  mod_q,
    output logic              tc,
    output logic              wrap_o,
    output logic              sat_o,
    output logic              err_o
);

    // Extended width: one bit wider than the widest operand so that
    // count+step and count+M-step can never overflow.
    localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] r_count_reg, r_count_next;
    logic [WIDTH-1:0] r_mod_reg, r_mod_next;
    logic             r_wrap_reg, r_wrap_next;
    logic             r_sat_reg, r_sat_next;
    logic             r_err_reg, r_err_next;

    logic [EW-1:0] w_cnt_e;
    logic [EW-1:0] w_mod_e;
    logic [EW-1:0] w_step_e;
    logic [EW-1:0] w_up_sum;
    logic [EW-1:0] w_up_wrap;
    logic [EW-1:0] w_dn_diff;
    logic [EW-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_mod_m1;

    assign w_cnt_e   = EW'(r_count_reg);
    assign w_mod_e   = EW'(r_mod_reg);
    assign w_step_e  = EW'(step);
    assign w_up_sum  = w_cnt_e + w_step_e;
    assign w_up_wrap = w_up_sum - w_mod_e;
    assign w_dn_diff = w_cnt_e - w_step_e;
    assign w_dn_wrap = w_cnt_e + w_mod_e - w_step_e;
    assign w_mod_m1  = r_mod_reg - WIDTH'(1);

    // Next-state selection: mod_wr beats load beats en; flags default low.
    always_comb begin
        r_count_next = r_count_reg;
        r_mod_next   = r_mod_reg;
        r_wrap_next  = 1'b0;
        r_sat_next   = 1'b0;
        r_err_next   = 1'b0;
        if (mod_wr) begin
            if (mod_val < WIDTH'(2)) begin
                r_err_next = 1'b1;
            end else begin
                r_mod_next = mod_val;
                if (r_count_reg >= mod_val) begin
                    r_count_next = '0;
                end
            end
        end else if (load) begin
            if (load_val < r_mod_reg) begin
                r_count_next = load_val;
            end else begin
                r_count_next = w_mod_m1;
                r_err_next   = 1'b1;
            end
        end else if (en) begin
            if (w_step_e == '0) begin
                r_count_next = r_count_reg;
            end else if (w_step_e >= w_mod_e) begin
                r_err_next = 1'b1;
            end else if (up_dn) begin
                if (w_up_sum < w_mod_e) begin
                    r_count_next = w_up_sum[WIDTH-1:0];
                end else if (sat_mode) begin
                    r_count_next = w_mod_m1;
                    r_sat_next   = 1'b1;
                end else begin
                    r_count_next = w_up_wrap[WIDTH-1:0];
                    r_wrap_next  = 1'b1;
                end
            end else begin
                if (w_cnt_e >= w_step_e) begin
                    r_count_next = w_dn_diff[WIDTH-1:0];
                end else if (sat_mode) begin
                    r_count_next = '0;
                    r_sat_next   = 1'b1;
                end else begin
                    r_count_next = w_dn_wrap[WIDTH-1:0];
                    r_wrap_next  = 1'b1;
                end
            end
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_reg <= '0;
            r_mod_reg   <= WIDTH'(DEFAULT_MOD);
            r_wrap_reg  <= 1'b0;
            r_sat_reg   <= 1'b0;
            r_err_reg   <= 1'b0;
        end else begin
            r_count_reg <= r_count_next;
            r_mod_reg   <= r_mod_next;
            r_wrap_reg  <= r_wrap_next;
            r_sat_reg   <= r_sat_next;
            r_err_reg   <= r_err_next;
        end
    end

    assign count  = r_count_reg;
    assign mod_q  = r_mod_reg;
    assign wrap_o = r_wrap_reg;
    assign sat_o  = r_sat_reg;
    assign err_o  = r_err_reg;
    assign tc     = up_dn ? (r_count_reg == w_mod_m1) : (r_count_reg == '0);

endmodule
